// File: rtl/pkt_sched.sv
// pkt_sched: sequences bursts of packet writes on the FIFO packet writer,
// with a programmable inter-packet gap and a per-packet done timeout.
module pkt_sched #(
    parameter int TIMEOUT = 4096,
    parameter int GAP_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             trig,
    input  logic [15:0]      cfg_cnt,
    input  logic [11:0]      cfg_len,
    input  logic [GAP_W-1:0] cfg_gap,
    input  logic             err_clr,
    output logic             fs,
    input  logic             fd,
    output logic [11:0]      data_len,
    output logic [15:0]      part,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [15:0]      sent
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_CLOSE = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5,
        S_FAULT = 3'd6
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [TW-1:0]    r_tmo;
    logic [GAP_W-1:0] r_gcnt;
    logic [GAP_W-1:0] r_gap;
    logic [15:0]      r_target;
    logic [11:0]      r_len;
    logic [15:0]      r_part;
    logic [15:0]      r_sent;
    logic             w_last;
    logic             w_close_exit;

    assign w_last       = (r_target != 16'd0) && ((r_sent + 16'd1) == r_target);
    assign w_close_exit = (r_state == S_CLOSE) && !fd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (trig && en) w_next = S_LOAD;
            end
            S_LOAD: begin
                w_next = S_START;
            end
            S_START: begin
                // a done arriving on the final allowed cycle still counts
                if (fd)                     w_next = S_CLOSE;
                else if (r_tmo == TMO_LAST) w_next = S_FAULT;
            end
            S_CLOSE: begin
                if (!fd) begin
                    if (w_last || !en)      w_next = S_DONE;
                    else if (r_gap == '0)   w_next = S_START;
                    else                    w_next = S_GAP;
                end
            end
            S_GAP: begin
                if (!en)                    w_next = S_DONE;
                else if (r_gcnt == '0)      w_next = S_START;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            S_FAULT: begin
                if (err_clr) w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo <= '0;
        end else if ((r_state == S_START) && (w_next == S_START)) begin
            r_tmo <= r_tmo + TW'(1);
        end else begin
            r_tmo <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gcnt <= '0;
        end else if (w_next == S_GAP) begin
            if (r_state == S_GAP) r_gcnt <= r_gcnt - GAP_W'(1);
            else                  r_gcnt <= r_gap - GAP_W'(1);
        end else begin
            r_gcnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gap    <= '0;
            r_target <= '0;
            r_len    <= '0;
        end else if (r_state == S_LOAD) begin
            r_gap    <= cfg_gap;
            r_target <= cfg_cnt;
            r_len    <= cfg_len;
        end
    end

    // part and sent advance together so part is stable for the whole fs window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_part <= '0;
            r_sent <= '0;
        end else if (r_state == S_LOAD) begin
            r_part <= '0;
            r_sent <= '0;
        end else if (w_close_exit) begin
            r_part <= r_part + 16'd1;
            r_sent <= r_sent + 16'd1;
        end
    end

    assign fs       = (r_state == S_START);
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign err      = (r_state == S_FAULT);
    assign data_len = r_len;
    assign part     = r_part;
    assign sent     = r_sent;

endmodule

// File: doc/pkt_sched.md
# pkt_sched

Packet scheduler that sequences the FIFO packet writer. On a trigger it runs a burst of packet writes: it raises the writer's start strobe `fs`, waits for its done flag `fd`, releases the strobe, and advances the packet sequence number `part`. It inserts a programmable idle gap between packets and guards each packet with a timeout. It sits between the host/config registers and the FIFO packet writer, and owns that writer's `fs`, `part` and `data_len` inputs.

## Interface
Parameters:
- `TIMEOUT`, default 4096: cycles allowed from `fs` rising to `fd` rising before a fault is declared (minimum 2).
- `GAP_W`, default 16: width of the inter-packet gap counter.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `en`  in  1  run enable; sampled at trigger and after each packet.
- `trig`  in  1  single-cycle burst start request.
- `cfg_cnt`  in  16  packets per burst; 0 = continuous while `en`=1.
- `cfg_len`  in  12  payload length passed to the writer.
- `cfg_gap`  in  GAP_W  idle cycles between packets.
- `err_clr`  in  1  clears the fault state.
- `fs`  out  1  start strobe to the writer.
- `fd`  in  1  done flag from the writer (held high until `fs` falls).
- `data_len`  out  12  latched copy of `cfg_len`.
- `part`  out  16  current packet sequence number.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse at burst end.
- `err`  out  1  high while in FAULT.
- `sent`  out  16  packets completed in the current burst.

## Operation
- States: IDLE, LOAD, START, CLOSE, GAP, DONE, FAULT. Use a one-hot or binary encoding; any unused encoding returns to IDLE.
- IDLE: when `trig`=1 and `en`=1, go to LOAD. Otherwise `trig` is ignored.
- LOAD (1 cycle): latch `cfg_len`→`data_len`, `cfg_cnt`→internal target, `cfg_gap`→gap reload. Set `part`←0 and `sent`←0. Go to START.
- START: `fs`=1; the timeout counter increments each cycle.
  - `fd`=1 → CLOSE.
  - Counter reaches TIMEOUT-1 while `fd`=0 → FAULT.
  - If `fd`=1 on the same cycle the counter reaches TIMEOUT-1, `fd` wins.
- CLOSE: `fs`=0; wait for `fd`=0. On the exit cycle, `sent`←`sent`+1 and `part`←`part`+1 (16-bit wrap, 0xFFFF→0x0000). Next state:
  - target≠0 and `sent`+1==target → DONE.
  - else `en`=0 → DONE.
  - else `cfg_gap`==0 → START.
  - else → GAP.
- GAP: down-counter loaded with gap reload-1 on entry; at 0 → START. If `en` falls during GAP → DONE.
- DONE (1 cycle): `done`=1, then IDLE. `part`, `sent` and `data_len` hold their values until the next LOAD.
- FAULT: `fs`=0, `err`=1; `sent` and `part` hold. `err_clr`=1 → IDLE. `trig` is ignored while in FAULT.
- The timeout counter clears on every entry to START. Config inputs are not re-sampled mid-burst.
- Reset, including mid-burst: state IDLE; `fs`, `busy`, `done`, `err` all 0; `data_len`, `part`, `sent` all 0; all counters 0.

## Timing
- From `trig` sampled high in IDLE: LOAD at cycle +1; `fs` high at cycle +2.
- `fs` falls on the cycle after `fd` is sampled high (CLOSE entry is registered).
- Next `fs` rise after `fd` is sampled low:
  - with `cfg_gap`=0: the following cycle;
  - with `cfg_gap`=G: G cycles of GAP, then START.
- `part` changes only on CLOSE exit, so it is stable for the whole `fs` high window.
- `done` is asserted exactly one cycle, the cycle after CLOSE or GAP exit.
- All outputs are registered or decoded from state only; none depends combinationally on inputs.

## Test plan
- Burst of 3 (`cfg_cnt`=3, `cfg_len`=16, `cfg_gap`=0, writer model with `fd` 20 cycles after `fs`) → three `fs` pulses with `part`=0,1,2; `sent`=3; one `done` pulse; final `part`=3.
- Gap check (`cfg_gap`=5) → exactly 5 cycles in GAP between `fd` falling and the next `fs` rising; `data_len` stays 16 throughout.
- Timeout (TIMEOUT=64, `fd` never rises) → `fs` drops and `err`=1 at cycle 64 of START; `err_clr` returns to IDLE; a new `trig` restarts with `part`=0.
- Continuous mode (`cfg_cnt`=0), `en` deasserted after packet 5 → packet 5 completes, then `done`, `sent`=5. Start `part` near 0xFFFE (force via a long run) and confirm the wrap 0xFFFF→0x0000.
- Async `rst` pulsed mid-START → `fs`=0 and `busy`=0 immediately; all outputs 0; `trig` in FAULT or mid-burst is ignored.
- Simultaneous `fd` rise and timeout expiry → CLOSE taken, no `err`.
